// File: rtl/srpt_send_scheduler_pkg.sv
// Common types for the SRPT send scheduler: entry width, output-slot state and field helpers.
`include "srpt_queue_defs.sv"

package srpt_send_scheduler_pkg;

  localparam int ENTRY_W = `QUEUE_ENTRY_SIZE;

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [15:0] entry_rpc_id(input entry_t e);
    return e[`QUEUE_ENTRY_RPC_ID];
  endfunction

endpackage

// File: rtl/srpt_queue_defs.sv
// Shared srpt_queue entry layout: total entry width and field bit ranges.
// Every block that carries queue entries includes this header rather than redefining them.
`ifndef SRPT_QUEUE_DEFS_SV
`define SRPT_QUEUE_DEFS_SV
`define QUEUE_ENTRY_SIZE      64
`define QUEUE_ENTRY_RPC_ID    15:0
`define QUEUE_ENTRY_DBUFF_ID  25:16
`define QUEUE_ENTRY_REMAINING 45:26
`define QUEUE_ENTRY_GRANTED   63:46
`endif

// File: rtl/srpt_rr_arb2.sv
// Two-input round-robin arbiter feeding a single full-throughput output register.
// rr_ptr only moves when both sources contend, so a lone requester never steals the turn.
`include "srpt_queue_defs.sv"

module srpt_rr_arb2
  import srpt_send_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               s0_valid,
  output logic               s0_ready,
  input  logic [ENTRY_W-1:0] s0_data,
  input  logic               s1_valid,
  output logic               s1_ready,
  input  logic [ENTRY_W-1:0] s1_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ENTRY_W-1:0] m_data
);

  slot_state_e        state_q, state_d;
  logic [ENTRY_W-1:0] data_q, data_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               load_en, grant0, grant1;

  // The slot can take a new entry when empty or when its current entry leaves this cycle.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    load_en  = !rst && ((state_q == SLOT_EMPTY) || m_ready);
    grant0   = load_en && s0_valid && (!s1_valid || !rr_ptr_q);
    grant1   = load_en && s1_valid && (!s0_valid || rr_ptr_q);
    if (load_en) begin
      state_d = (grant0 || grant1) ? SLOT_FULL : SLOT_EMPTY;
      if (grant0) begin
        data_d = s0_data;
      end else if (grant1) begin
        data_d = s1_data;
      end
      if (s0_valid && s1_valid) begin
        rr_ptr_d = !rr_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SLOT_EMPTY;
      data_q   <= '0;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign s0_ready = grant0;
  assign s1_ready = grant1;
  assign m_valid  = (state_q == SLOT_FULL);
  assign m_data   = data_q;

endmodule

// File: rtl/srpt_send_scheduler.sv
// SRPT send scheduler: merges sendmsg and update streams into the SRPT queue, and paces
// queue output to egress with a credit counter replenished by PKT_DONE.
`include "srpt_queue_defs.sv"

module srpt_send_scheduler
  import srpt_send_scheduler_pkg::*;
#(
  parameter int CREDITS = 8,
  parameter int CW      = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         S0_AXIS_TVALID,
  output logic                         S0_AXIS_TREADY,
  input  logic [`QUEUE_ENTRY_SIZE-1:0] S0_AXIS_TDATA,
  input  logic                         S1_AXIS_TVALID,
  output logic                         S1_AXIS_TREADY,
  input  logic [`QUEUE_ENTRY_SIZE-1:0] S1_AXIS_TDATA,
  output logic                         ENQ_AXIS_TVALID,
  input  logic                         ENQ_AXIS_TREADY,
  output logic [`QUEUE_ENTRY_SIZE-1:0] ENQ_AXIS_TDATA,
  input  logic                         DEQ_AXIS_TVALID,
  output logic                         DEQ_AXIS_TREADY,
  input  logic [`QUEUE_ENTRY_SIZE-1:0] DEQ_AXIS_TDATA,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [`QUEUE_ENTRY_SIZE-1:0] M_AXIS_TDATA,
  input  logic                         PKT_DONE,
  output logic [CW-1:0]                CREDITS_AVAIL,
  output logic                         CREDIT_ERR
);

  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  slot_state_e        m_state_q, m_state_d;
  logic [ENTRY_W-1:0] m_data_q, m_data_d;
  logic [CW-1:0]      credits_q, credits_d;
  logic               credit_err_q, credit_err_d;
  logic               deq_fire;

  srpt_rr_arb2 u_enq_arb (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .s0_valid (S0_AXIS_TVALID),
    .s0_ready (S0_AXIS_TREADY),
    .s0_data  (S0_AXIS_TDATA),
    .s1_valid (S1_AXIS_TVALID),
    .s1_ready (S1_AXIS_TREADY),
    .s1_data  (S1_AXIS_TDATA),
    .m_valid  (ENQ_AXIS_TVALID),
    .m_ready  (ENQ_AXIS_TREADY),
    .m_data   (ENQ_AXIS_TDATA)
  );

  assign DEQ_AXIS_TREADY = (credits_q != '0) && ((m_state_q == SLOT_EMPTY) || M_AXIS_TREADY);
  assign deq_fire        = DEQ_AXIS_TVALID && DEQ_AXIS_TREADY;

  // A credit taken and a credit returned in the same cycle cancel; an extra return is flagged.
  always_comb begin
    m_state_d    = m_state_q;
    m_data_d     = m_data_q;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (deq_fire) begin
      m_state_d = SLOT_FULL;
      m_data_d  = DEQ_AXIS_TDATA;
    end else if (M_AXIS_TREADY) begin
      m_state_d = SLOT_EMPTY;
    end
    case ({deq_fire, PKT_DONE})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CREDIT_MAX) begin
          credit_err_d = 1'b1;
        end else begin
          credits_d = credits_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      m_state_q    <= SLOT_EMPTY;
      m_data_q     <= '0;
      credits_q    <= CREDIT_MAX;
      credit_err_q <= 1'b0;
    end else begin
      m_state_q    <= m_state_d;
      m_data_q     <= m_data_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign M_AXIS_TVALID = (m_state_q == SLOT_FULL);
  assign M_AXIS_TDATA  = m_data_q;
  assign CREDITS_AVAIL = credits_q;
  assign CREDIT_ERR    = credit_err_q;

endmodule

// File: tb/tb_srpt_send_scheduler.sv
// Scoreboard bench for srpt_send_scheduler: directed scenarios then a random phase,
// with a transaction-level reference model predicting arbitration order and credit flow.
module tb_srpt_send_scheduler;
  import srpt_send_scheduler_pkg::*;

  localparam int CREDITS = 8;
  localparam int CW      = 8;
  localparam int W       = ENTRY_W;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          s0_valid, s0_ready, s1_valid, s1_ready;
  logic [W-1:0]  s0_data, s1_data;
  logic          enq_valid, enq_ready;
  logic [W-1:0]  enq_data;
  logic          deq_valid, deq_ready;
  logic [W-1:0]  deq_data;
  logic          m_valid, m_ready;
  logic [W-1:0]  m_data;
  logic          pkt_done;
  logic [CW-1:0] credits_avail;
  logic          credit_err;

  srpt_send_scheduler #(.CREDITS(CREDITS), .CW(CW)) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .S0_AXIS_TVALID  (s0_valid),
    .S0_AXIS_TREADY  (s0_ready),
    .S0_AXIS_TDATA   (s0_data),
    .S1_AXIS_TVALID  (s1_valid),
    .S1_AXIS_TREADY  (s1_ready),
    .S1_AXIS_TDATA   (s1_data),
    .ENQ_AXIS_TVALID (enq_valid),
    .ENQ_AXIS_TREADY (enq_ready),
    .ENQ_AXIS_TDATA  (enq_data),
    .DEQ_AXIS_TVALID (deq_valid),
    .DEQ_AXIS_TREADY (deq_ready),
    .DEQ_AXIS_TDATA  (deq_data),
    .M_AXIS_TVALID   (m_valid),
    .M_AXIS_TREADY   (m_ready),
    .M_AXIS_TDATA    (m_data),
    .PKT_DONE        (pkt_done),
    .CREDITS_AVAIL   (credits_avail),
    .CREDIT_ERR      (credit_err)
  );

  always #5 ap_clk = ~ap_clk;

  int errors = 0;
  int checks = 0;

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] src_word(input logic [7:0] tag, input int idx);
    logic [31:0] mix;
    mix = 32'(idx) * 32'h9E37_79B1;
    return W'({tag, 24'(idx), mix});
  endfunction

  // Reference model: one-deep slots, alternating turn under contention, integer credit pool.
  logic [W-1:0] enq_exp_q[$];
  logic [W-1:0] m_exp_q[$];
  logic [W-1:0] enq_log[$];
  int  turn, enq_occ, m_occ, model_credits;
  bit  model_err;
  bit  s0_fired, s1_fired, deq_fired;
  int  m_count = 0;

  always @(negedge ap_clk) begin
    bit can_take, g0, g1, exp_deq_ready, deq_go, m_go;
    if (ap_rst) begin
      turn = 0; enq_occ = 0; m_occ = 0; model_credits = CREDITS; model_err = 0;
      enq_exp_q.delete(); m_exp_q.delete();
      s0_fired = 0; s1_fired = 0; deq_fired = 0;
    end else begin
      can_take = (enq_occ == 0) || enq_ready;
      g0 = can_take && s0_valid && (!s1_valid || turn == 0);
      g1 = can_take && s1_valid && (!s0_valid || turn == 1);
      check_output("s0_ready", W'(s0_ready), W'(g0));
      check_output("s1_ready", W'(s1_ready), W'(g1));
      check_output("enq_valid", W'(enq_valid), W'(enq_occ));
      if (g0) enq_exp_q.push_back(s0_data);
      if (g1) enq_exp_q.push_back(s1_data);
      if (can_take && s0_valid && s1_valid) turn = 1 - turn;
      if (g0 || g1) enq_occ = 1;
      else if (enq_occ == 1 && enq_ready) enq_occ = 0;

      exp_deq_ready = (model_credits > 0) && (m_occ == 0 || m_ready);
      check_output("deq_ready", W'(deq_ready), W'(exp_deq_ready));
      check_output("m_valid", W'(m_valid), W'(m_occ));
      check_output("credits_avail", W'(credits_avail), W'(model_credits));
      check_output("credit_err", W'(credit_err), W'(model_err));
      deq_go = deq_valid && exp_deq_ready;
      m_go   = (m_occ == 1) && m_ready;
      if (deq_go) m_exp_q.push_back(deq_data);
      m_occ = m_occ - int'(m_go) + int'(deq_go);
      if (deq_go && !pkt_done) model_credits--;
      else if (pkt_done && !deq_go) begin
        if (model_credits == CREDITS) model_err = 1;
        else model_credits++;
      end

      s0_fired  = s0_valid && s0_ready;
      s1_fired  = s1_valid && s1_ready;
      deq_fired = deq_valid && deq_ready;
    end
  end

  // Output monitor: pops the scoreboard whenever an output handshake happens.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (enq_valid && enq_ready) begin
        enq_log.push_back(enq_data);
        if (enq_exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL enq_extra: got 0x%0h, expected no entry", enq_data);
        end else begin
          check_output("enq_data", enq_data, enq_exp_q.pop_front());
        end
      end
      if (m_valid && m_ready) begin
        m_count++;
        if (m_exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL m_extra: got 0x%0h, expected no entry", m_data);
        end else begin
          check_output("m_data", m_data, m_exp_q.pop_front());
        end
      end
    end
  end

  // Source drivers: hold each item until its handshake, then advance.
  int s0_left = 0, s1_left = 0, deq_left = 0;
  int s0_idx = 0, s1_idx = 0, deq_idx = 0;
  bit rand_mode = 0;

  task automatic apply_stimulus();
    bit f0, f1, fd;
    f0 = s0_fired; f1 = s1_fired; fd = deq_fired;
    s0_fired = 0; s1_fired = 0; deq_fired = 0;
    if (f0) begin s0_idx++; s0_left--; end
    if (f1) begin s1_idx++; s1_left--; end
    if (fd) begin deq_idx++; deq_left--; end
    if (rand_mode) begin
      if (!s0_valid || f0) s0_valid = (s0_left > 0) && ($urandom_range(0, 1) == 1);
      if (!s1_valid || f1) s1_valid = (s1_left > 0) && ($urandom_range(0, 1) == 1);
      if (!deq_valid || fd) deq_valid = (deq_left > 0) && ($urandom_range(0, 2) != 0);
      enq_ready = ($urandom_range(0, 3) != 0);
      m_ready   = ($urandom_range(0, 3) != 0);
      pkt_done  = ($urandom_range(0, 3) == 0);
    end else begin
      s0_valid  = (s0_left > 0);
      s1_valid  = (s1_left > 0);
      deq_valid = (deq_left > 0);
    end
    s0_data  = src_word(8'hA0, s0_idx);
    s1_data  = src_word(8'hB1, s1_idx);
    deq_data = src_word(8'hD2, deq_idx);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
    apply_stimulus();
  endtask

  task automatic pulse_done();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    tick();
  endtask

  initial begin
    int b0, b1, held_idx, m_base;
    ap_rst = 1'b1;
    s0_valid = 1'b1; s0_data = src_word(8'hA0, 0);
    s1_valid = 1'b1; s1_data = src_word(8'hB1, 0);
    deq_valid = 1'b0; deq_data = '0;
    enq_ready = 1'b1; m_ready = 1'b1; pkt_done = 1'b0;
    #12;
    check_output("rst_s0_ready", W'(s0_ready), W'(0));
    check_output("rst_s1_ready", W'(s1_ready), W'(0));
    check_output("rst_enq_valid", W'(enq_valid), W'(0));
    check_output("rst_credits", W'(credits_avail), W'(CREDITS));
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick();
    ap_rst = 1'b0;
    repeat (3) tick();
    check_output("idle_credits", W'(credits_avail), W'(8));
    check_output("idle_enq_valid", W'(enq_valid), W'(0));
    check_output("idle_m_valid", W'(m_valid), W'(0));
    check_output("idle_credit_err", W'(credit_err), W'(0));

    // Both sources contend: output must alternate S0, S1, S0, S1.
    b0 = s0_idx; b1 = s1_idx;
    enq_log.delete();
    s0_left = 2; s1_left = 2;
    apply_stimulus();
    repeat (8) tick();
    check_output("rr_count", W'(enq_log.size()), W'(4));
    if (enq_log.size() == 4) begin
      check_output("rr_order0", enq_log[0], src_word(8'hA0, b0));
      check_output("rr_order1", enq_log[1], src_word(8'hB1, b1));
      check_output("rr_order2", enq_log[2], src_word(8'hA0, b0 + 1));
      check_output("rr_order3", enq_log[3], src_word(8'hB1, b1 + 1));
    end

    // Backpressure: held entry stays put and neither source is accepted.
    enq_ready = 1'b0;
    s0_left = 2;
    held_idx = s0_idx;
    apply_stimulus();
    tick();
    s1_left = 1;
    apply_stimulus();
    for (int i = 0; i < 5; i++) begin
      check_output("hold_data", enq_data, src_word(8'hA0, held_idx));
      check_output("hold_s0_ready", W'(s0_ready), W'(0));
      check_output("hold_s1_ready", W'(s1_ready), W'(0));
      tick();
    end
    enq_ready = 1'b1;
    repeat (6) tick();

    // Credit exhaustion: 10 offered, only 8 pass until a credit returns.
    m_base = m_count;
    deq_left = 10;
    apply_stimulus();
    repeat (20) tick();
    check_output("credit_emitted8", W'(m_count - m_base), W'(8));
    check_output("credit_zero", W'(credits_avail), W'(0));
    check_output("credit_zero_ready", W'(deq_ready), W'(0));
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    repeat (5) tick();
    check_output("credit_emitted9", W'(m_count - m_base), W'(9));
    deq_left = 0;
    apply_stimulus();
    repeat (3) pulse_done();
    check_output("credit_three", W'(credits_avail), W'(3));
    deq_left = 1;
    apply_stimulus();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    check_output("coincident_credits", W'(credits_avail), W'(3));
    repeat (3) tick();

    // Over-return raises the sticky error without exceeding the maximum.
    repeat (5) pulse_done();
    check_output("full_credits", W'(credits_avail), W'(8));
    check_output("full_no_err", W'(credit_err), W'(0));
    pulse_done();
    check_output("over_err", W'(credit_err), W'(1));
    check_output("over_credits", W'(credits_avail), W'(8));

    // Reset while both paths hold entries.
    enq_ready = 1'b0; m_ready = 1'b0;
    s0_left = 5; s1_left = 5; deq_left = 5;
    apply_stimulus();
    repeat (3) tick();
    ap_rst = 1'b1;
    #2;
    check_output("midrst_enq_valid", W'(enq_valid), W'(0));
    check_output("midrst_m_valid", W'(m_valid), W'(0));
    check_output("midrst_credits", W'(credits_avail), W'(8));
    check_output("midrst_err", W'(credit_err), W'(0));
    check_output("midrst_s0_ready", W'(s0_ready), W'(0));
    s0_left = 0; s1_left = 0; deq_left = 0;
    enq_ready = 1'b1; m_ready = 1'b1;
    apply_stimulus();
    repeat (2) tick();
    ap_rst = 1'b0;

    // Random traffic on both paths, checked by the model and scoreboard.
    rand_mode = 1;
    s0_left = 1000000; s1_left = 1000000; deq_left = 1000000;
    apply_stimulus();
    repeat (3000) tick();
    rand_mode = 0;
    s0_left = 0; s1_left = 0; deq_left = 0;
    enq_ready = 1'b1; m_ready = 1'b1; pkt_done = 1'b0;
    apply_stimulus();
    repeat (10) tick();
    check_output("drain_enq_queue", W'(enq_exp_q.size()), W'(0));
    check_output("drain_m_queue", W'(m_exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
